// File: rtl/pipe_ctrl_gen_pkg.sv
// Shared constants for the pipeline control unit: MIPS exception codes, FSM encodings,
// stage indices and the recognised-cause helper.
package pipe_ctrl_gen_pkg;

   localparam logic [31:0] EXC_INT     = 32'h0000_0001;
   localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
   localparam logic [31:0] EXC_RI      = 32'h0000_000a;
   localparam logic [31:0] EXC_OV      = 32'h0000_000c;
   localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
   localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

   typedef enum logic [0:0] {
      STATE_IDLE  = 1'b0,
      STATE_FLUSH = 1'b1
   } state_e;

   localparam int unsigned STG_PC  = 0;
   localparam int unsigned STG_IF  = 1;
   localparam int unsigned STG_ID  = 2;
   localparam int unsigned STG_EX  = 3;
   localparam int unsigned STG_MEM = 4;
   localparam int unsigned STG_WB  = 5;

   function automatic logic exc_known(input logic [31:0] code);
      logic known;
      known = 1'b0;
      case (code)
         EXC_INT, EXC_SYSCALL, EXC_RI, EXC_OV, EXC_TRAP, EXC_ERET: known = 1'b1;
         default: known = 1'b0;
      endcase
      return known;
   endfunction

endpackage

// File: rtl/pipe_ctrl_gen_stall_mask_gen.sv
// Thermometer stall mask: every stage at or below the highest requesting stage is held.
module pipe_ctrl_gen_stall_mask_gen #(
   parameter int unsigned STAGES = 6
) (
   input  logic [STAGES-1:0] req_i,
   output logic [STAGES-1:0] mask_o
);

   logic acc;

   always_comb begin
      mask_o = '0;
      acc    = 1'b0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         acc       = acc | req_i[k];
         mask_o[k] = acc;
      end
   end

endmodule

// File: rtl/pipe_ctrl_gen.sv
// Pipeline control unit: exception-driven flush/redirect sequencer, per-stage stall mask
// and a stall watchdog with a saturating consecutive-stall counter.
module pipe_ctrl_gen
   import pipe_ctrl_gen_pkg::*;
#(
   parameter int unsigned       STAGES        = 6,
   parameter int unsigned       DATA_W        = 32,
   parameter logic [DATA_W-1:0] EXC_BASE      = DATA_W'(32'h0000_0020),
   parameter int unsigned       FLUSH_CYCLES  = 1,
   parameter int unsigned       STALL_TIMEOUT = 1024,
   parameter int unsigned       CNT_W         = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       excepttype_i,
   input  logic [DATA_W-1:0] cp0_epc_i,
   input  logic [STAGES-1:0] stallreq_i,
   output logic [DATA_W-1:0] new_pc,
   output logic              flush,
   output logic [STAGES-1:0] stall,
   output logic              redirect_o,
   output logic              exc_unknown_o,
   output logic              stall_timeout_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   localparam int unsigned      FcW        = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(STALL_TIMEOUT - 1);

   state_e              state_q, state_d;
   logic [FcW-1:0]      flush_cnt_q, flush_cnt_d;
   logic [DATA_W-1:0]   held_pc_q, held_pc_d;
   logic                exc_unknown_q, exc_unknown_d;
   logic                stall_timeout_q, stall_timeout_d;
   logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

   logic [STAGES-1:0]   mask;
   logic [DATA_W-1:0]   target;
   logic                exc_hit;

   pipe_ctrl_gen_stall_mask_gen #(
      .STAGES(STAGES)
   ) u_mask (
      .req_i (stallreq_i),
      .mask_o(mask)
   );

   assign target  = (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_BASE;
   assign exc_hit = (state_q == STATE_IDLE) && (excepttype_i != '0);

   // Outputs are combinational and held at zero for the whole reset assertion.
   always_comb begin
      flush      = 1'b0;
      stall      = '0;
      new_pc     = '0;
      redirect_o = 1'b0;
      if (!rst) begin
         if (state_q == STATE_FLUSH) begin
            flush  = 1'b1;
            new_pc = held_pc_q;
         end else if (exc_hit) begin
            flush      = 1'b1;
            redirect_o = 1'b1;
            new_pc     = target;
         end else begin
            stall = mask;
         end
      end
   end

   always_comb begin
      state_d         = state_q;
      flush_cnt_d     = flush_cnt_q;
      held_pc_d       = held_pc_q;
      exc_unknown_d   = exc_unknown_q;
      stall_timeout_d = stall_timeout_q;
      stall_cnt_d     = stall_cnt_q;

      case (state_q)
         STATE_IDLE: begin
            if (exc_hit) begin
               held_pc_d = target;
               if (!exc_known(excepttype_i)) exc_unknown_d = 1'b1;
               if (FLUSH_CYCLES > 1) begin
                  state_d     = STATE_FLUSH;
                  flush_cnt_d = FcW'(FLUSH_CYCLES - 1);
               end
            end
         end
         STATE_FLUSH: begin
            flush_cnt_d = flush_cnt_q - FcW'(1);
            if (flush_cnt_q == FcW'(1)) state_d = STATE_IDLE;
         end
         default: state_d = STATE_IDLE;
      endcase

      if (flush || (stall == '0)) begin
         stall_cnt_d = '0;
      end else if (stall_cnt_q != '1) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if ((stall != '0) && (stall_cnt_q == TimeoutCnt)) stall_timeout_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= STATE_IDLE;
         flush_cnt_q     <= '0;
         held_pc_q       <= '0;
         exc_unknown_q   <= 1'b0;
         stall_timeout_q <= 1'b0;
         stall_cnt_q     <= '0;
      end else begin
         state_q         <= state_d;
         flush_cnt_q     <= flush_cnt_d;
         held_pc_q       <= held_pc_d;
         exc_unknown_q   <= exc_unknown_d;
         stall_timeout_q <= stall_timeout_d;
         stall_cnt_q     <= stall_cnt_d;
      end
   end

   assign exc_unknown_o   = exc_unknown_q;
   assign stall_timeout_o = stall_timeout_q;
   assign stall_cnt_o     = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// Directed bench: instance A (6 stages, 3-cycle flush, timeout 4), instance B (8 stages, 1-cycle flush).
module tb_pipe_ctrl_gen;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [31:0] a_exc = '0;
   logic [31:0] a_epc = '0;
   logic [5:0]  a_req = '0;
   logic [31:0] a_new_pc;
   logic        a_flush, a_redirect, a_unknown, a_timeout;
   logic [5:0]  a_stall;
   logic [15:0] a_cnt;

   logic [31:0] b_exc = '0;
   logic [31:0] b_epc = '0;
   logic [7:0]  b_req = '0;
   logic [31:0] b_new_pc;
   logic        b_flush, b_redirect, b_unknown, b_timeout;
   logic [7:0]  b_stall;
   logic [15:0] b_cnt;

   int total = 0;
   int bad   = 0;

   pipe_ctrl_gen #(
      .STAGES(6), .DATA_W(32), .FLUSH_CYCLES(3), .STALL_TIMEOUT(4), .CNT_W(16)
   ) dut_a (
      .clk(clk), .rst(rst), .excepttype_i(a_exc), .cp0_epc_i(a_epc), .stallreq_i(a_req),
      .new_pc(a_new_pc), .flush(a_flush), .stall(a_stall), .redirect_o(a_redirect),
      .exc_unknown_o(a_unknown), .stall_timeout_o(a_timeout), .stall_cnt_o(a_cnt)
   );

   pipe_ctrl_gen #(
      .STAGES(8), .DATA_W(32), .FLUSH_CYCLES(1), .STALL_TIMEOUT(1024), .CNT_W(16)
   ) dut_b (
      .clk(clk), .rst(rst), .excepttype_i(b_exc), .cp0_epc_i(b_epc), .stallreq_i(b_req),
      .new_pc(b_new_pc), .flush(b_flush), .stall(b_stall), .redirect_o(b_redirect),
      .exc_unknown_o(b_unknown), .stall_timeout_o(b_timeout), .stall_cnt_o(b_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      // Reset values, with a stall request already present.
      a_req = 6'b001000;
      #2;
      chk("rst_a_stall", a_stall, 6'b000000);
      chk("rst_a_flush", a_flush, 1'b0);
      chk("rst_a_new_pc", a_new_pc, 32'h0);
      chk("rst_a_redirect", a_redirect, 1'b0);
      chk("rst_a_cnt", a_cnt, 16'h0);
      chk("rst_b_unknown", b_unknown, 1'b0);

      @(negedge clk); rst = 1'b0; #1;
      chk("post_rst_stall", a_stall, 6'b001111);
      @(negedge clk); #1;
      chk("cnt_after_1", a_cnt, 16'd1);
      // Mid-cycle reset: outputs and counter clear immediately.
      #2 rst = 1'b1; #1;
      chk("midrst_stall", a_stall, 6'b000000);
      chk("midrst_cnt", a_cnt, 16'd0);
      @(negedge clk); rst = 1'b0; a_req = '0; #1;
      chk("idle_stall_zero", a_stall, 6'b000000);

      // Thermometer mask combinations on A.
      a_req = 6'b001100; #1; chk("mask_id_ex", a_stall, 6'b001111);
      @(negedge clk); a_req = 6'b100000; #1; chk("mask_wb", a_stall, 6'b111111);
      @(negedge clk); a_req = 6'b000001; #1; chk("mask_pc", a_stall, 6'b000001);
      @(negedge clk); a_req = 6'b000000; #1;
      @(negedge clk); #1; chk("cnt_cleared", a_cnt, 16'd0);
      chk("no_timeout_yet", a_timeout, 1'b0);

      // Priority on B: build up stall count, then an exception overrides it.
      b_req = 8'b0000_1100;
      @(negedge clk); @(negedge clk); #1;
      chk("b_cnt_2", b_cnt, 16'd2);
      b_exc = 32'h08; #1;
      chk("prio_flush", b_flush, 1'b1);
      chk("prio_stall", b_stall, 8'h00);
      chk("prio_new_pc", b_new_pc, 32'h20);
      chk("prio_redirect", b_redirect, 1'b1);
      @(negedge clk); b_exc = '0; #1;
      chk("prio_cnt_clr", b_cnt, 16'd0);
      chk("prio_flush_done", b_flush, 1'b0);
      chk("prio_stall_back", b_stall, 8'b0000_1111);
      chk("prio_known", b_unknown, 1'b0);

      // Unknown cause on B.
      b_req = '0; b_exc = 32'h05; #1;
      chk("unk_flush", b_flush, 1'b1);
      chk("unk_new_pc", b_new_pc, 32'h20);
      chk("unk_not_yet", b_unknown, 1'b0);
      @(negedge clk); b_exc = '0; #1;
      chk("unk_set", b_unknown, 1'b1);
      chk("unk_flush_low", b_flush, 1'b0);
      @(negedge clk); @(negedge clk); #1;
      chk("unk_sticky", b_unknown, 1'b1);

      // Width generalisation on B.
      b_req = 8'b0100_0010; #1; chk("w8_mask", b_stall, 8'b0111_1111);
      b_req = 8'b1000_0000; #1; chk("w8_top", b_stall, 8'b1111_1111);
      @(negedge clk); b_req = '0;

      // ERET on A with a 3-cycle flush; a cause injected mid-flush is dropped.
      a_epc = 32'hBFC0_0100; a_exc = 32'h0e; a_req = 6'b000100; #1;
      chk("eret_c1_flush", a_flush, 1'b1);
      chk("eret_c1_redir", a_redirect, 1'b1);
      chk("eret_c1_pc", a_new_pc, 32'hBFC0_0100);
      chk("eret_c1_stall", a_stall, 6'b000000);
      @(negedge clk); a_exc = '0; a_epc = 32'h1234_5678; #1;
      chk("eret_c2_flush", a_flush, 1'b1);
      chk("eret_c2_redir", a_redirect, 1'b0);
      chk("eret_c2_pc", a_new_pc, 32'hBFC0_0100);
      chk("eret_c2_cnt", a_cnt, 16'd0);
      @(negedge clk); a_exc = 32'h0c; #1;
      chk("eret_c3_flush", a_flush, 1'b1);
      chk("eret_c3_redir", a_redirect, 1'b0);
      chk("eret_c3_pc", a_new_pc, 32'hBFC0_0100);
      @(negedge clk); a_exc = '0; #1;
      chk("eret_end_flush", a_flush, 1'b0);
      chk("eret_end_redir", a_redirect, 1'b0);
      chk("eret_end_pc", a_new_pc, 32'h0);
      chk("eret_end_stall", a_stall, 6'b000111);
      chk("eret_cnt0", a_cnt, 16'd0);

      // Watchdog on A: ID request held, trips after the fourth stall cycle.
      @(negedge clk); #1; chk("wd_cnt1", a_cnt, 16'd1);
      @(negedge clk); #1; chk("wd_cnt2", a_cnt, 16'd2);
      @(negedge clk); #1; chk("wd_cnt3", a_cnt, 16'd3);
      chk("wd_not_tripped", a_timeout, 1'b0);
      @(negedge clk); #1; chk("wd_cnt4", a_cnt, 16'd4);
      chk("wd_tripped", a_timeout, 1'b1);
      a_req = '0;
      @(negedge clk); #1;
      chk("wd_cnt_drop", a_cnt, 16'd0);
      chk("wd_sticky", a_timeout, 1'b1);
      chk("wd_a_known", a_unknown, 1'b0);

      // Reset clears sticky flags.
      rst = 1'b1; #1;
      chk("rst_clr_timeout", a_timeout, 1'b0);
      chk("rst_clr_unknown", b_unknown, 1'b0);
      @(negedge clk); rst = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl_gen.md
Name: pipe_ctrl_gen

Overview:
Parametrised pipeline control unit for the 89-instruction MIPS CPU. It generalises stall and flush generation to STAGES pipeline stages with a per-stage stall-request vector. It adds a multi-cycle flush sequencer, a configurable exception vector, and a stall watchdog with a saturating stall counter. It sits beside the pipeline, taking exception type and EPC from the MEM/CP0 path and driving stall, flush and redirect PC to every stage register and to the PC unit.

Parameters:
STAGES, 6, number of pipeline stage registers controlled; bit 0 = PC, 1 = IF, 2 = ID, 3 = EX, 4 = MEM, 5 = WB.
DATA_W, 32, PC/EPC width.
EXC_BASE, 32'h0000_0020, redirect target for every exception except ERET.
FLUSH_CYCLES, 1, cycles flush stays high per exception (>=1).
STALL_TIMEOUT, 1024, consecutive stall cycles before the watchdog trips (>=1).
CNT_W, 16, stall-cycle counter width.

Ports:
clk  in  1  system clock; all state on rising edge.
rst  in  1  asynchronous active-high reset.
excepttype_i  in  32  exception code from MEM stage; 0 = none.
cp0_epc_i  in  DATA_W  EPC from CP0, used for ERET.
stallreq_i  in  STAGES  per-stage stall request; bit k = stage k requests.
new_pc  out  DATA_W  redirect target, valid while flush=1.
flush  out  1  flush all stage registers.
stall  out  STAGES  stall mask to stage registers.
redirect_o  out  1  one-cycle pulse on the first flush cycle of each exception.
exc_unknown_o  out  1  sticky: a non-zero unrecognised excepttype was seen.
stall_timeout_o  out  1  sticky: watchdog tripped.
stall_cnt_o  out  CNT_W  consecutive-stall cycle count, saturating.

Behaviour:
- Reset (async, rst=1): state IDLE, flush_cnt=0, held_pc=0, all sticky flags 0, stall_cnt_o=0. Combinational outputs are forced to 0 while rst=1: flush=0, stall=0, new_pc=0, redirect_o=0.
- States: IDLE, FLUSH.
- Cause decode (combinational):
  - 0x01, 0x08, 0x0a, 0x0c, 0x0d -> EXC_BASE.
  - 0x0e (ERET) -> cp0_epc_i.
  - Any other non-zero code -> EXC_BASE and sets exc_unknown_o on the next edge.
- IDLE with excepttype_i != 0 (zero latency, same cycle):
  - flush=1, stall=0, redirect_o=1, new_pc=decoded target. Exceptions override all stall requests.
  - On the edge, held_pc <= target.
  - If FLUSH_CYCLES>1: go to FLUSH with flush_cnt=FLUSH_CYCLES-1. Otherwise stay in IDLE.
- FLUSH:
  - flush=1, stall=0, redirect_o=0, new_pc=held_pc.
  - excepttype_i and stallreq_i are ignored.
  - flush_cnt decrements each cycle; return to IDLE on the edge where flush_cnt==1.
- IDLE with no exception:
  - flush=0, redirect_o=0, new_pc=0.
  - stall: let h = highest set index of stallreq_i. stall[k]=1 for all k<=h, else 0. stallreq_i=0 gives stall=0.
  - Example, STAGES=6: EX request gives 6'b001111; ID request gives 6'b000111; EX and ID together give 6'b001111.
- Watchdog:
  - On each edge, stall_cnt_o increments (saturating at all-ones) if stall!=0.
  - It clears to 0 if stall==0 or flush==1.
  - When stall_cnt_o reaches STALL_TIMEOUT-1 and stall!=0, stall_timeout_o sets. It stays set until reset.
- Simultaneous events:
  - An exception and a stall request in the same cycle: exception wins; stall_cnt_o clears.
  - An exception arriving during FLUSH is dropped. The upstream CP0 is responsible for not generating one.
- Reset mid-FLUSH returns to IDLE immediately; flush drops asynchronously.

Decomposition:
- Shared package/defines: exception code constants (EXC_INT, EXC_SYSCALL, EXC_RI, EXC_OV, EXC_TRAP, EXC_ERET), STATE_IDLE/STATE_FLUSH encodings, and stage index constants (STG_PC…STG_WB). RstEnable/Stop stay in the existing defines.
- One natural sub-module: stall_mask_gen, a combinational thermometer mask from the highest set request bit, parametrised by STAGES.

Test Plan:
- Reset: assert rst mid-cycle with stallreq_i=6'b001000 -> all outputs 0 immediately; after release, stall=6'b001111.
- Priority: stallreq_i=6'b001100, excepttype_i=0x08 -> same cycle flush=1, stall=0, new_pc=32'h20, redirect_o=1; stall_cnt_o=0 next cycle.
- ERET with FLUSH_CYCLES=3: cp0_epc_i=32'hBFC0_0100, excepttype_i=0x0e for one cycle -> flush high exactly 3 cycles, new_pc=32'hBFC0_0100 in all 3, redirect_o high only in the first; a 0x0c injected in cycle 2 is ignored.
- Unknown code: excepttype_i=0x05 -> flush=1, new_pc=32'h20; exc_unknown_o=1 from the next cycle and stays until reset.
- Watchdog with STALL_TIMEOUT=4: hold stallreq_i=6'b000100 -> stall=6'b000111; stall_timeout_o sets after the 4th stall cycle. Drop the request -> stall_cnt_o=0, stall_timeout_o stays 1.
- Width generalisation, STAGES=8: stallreq_i=8'b0100_0010 -> stall=8'b0111_1111.
